// File: rtl/mem_access_unit.sv
// Load/store engine behind the multicycle controller's memory states.
// Takes one request (address, store data, funct3), runs a valid/ready
// handshake with a variable-latency data memory, builds byte strobes and
// replicated store data, and returns sign/zero-extended load data plus a
// one-cycle done (and fault) pulse.
//
//   state  | meaning
//   IDLE   | waiting for req_valid; request is checked and captured here
//   ACCESS | mem_valid high, waiting for mem_ready or the timeout
//   DONE   | one-cycle done pulse, access completed
//   FAULT  | one-cycle done+fault pulse (illegal, misaligned or timed out)
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata,
  output logic        mem_valid,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE, S_FAULT} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] addr_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic        req_legal;
  logic        req_aligned;
  logic        req_ok;
  logic [3:0]  req_wstrb;
  logic [31:0] req_wrep;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Request legality, alignment, strobes and lane-replicated store data
  always_comb begin
    req_legal   = 1'b0;
    req_aligned = 1'b1;
    req_wstrb   = 4'b0000;
    req_wrep    = 32'h0;
    if (req_we)
      req_legal = (req_funct3[2] == 1'b0) && (req_funct3[1:0] != 2'b11);
    else
      req_legal = (req_funct3[1:0] != 2'b11) &&
                  !(req_funct3[2] && (req_funct3[1:0] == 2'b10));
    case (req_funct3[1:0])
      2'b01:   req_aligned = (req_addr[0] == 1'b0);
      2'b10:   req_aligned = (req_addr[1:0] == 2'b00);
      default: req_aligned = 1'b1;
    endcase
    if (req_we) begin
      case (req_funct3[1:0])
        2'b00: begin
          req_wstrb = 4'b0001 << req_addr[1:0];
          req_wrep  = {4{req_wdata[7:0]}};
        end
        2'b01: begin
          req_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
          req_wrep  = {2{req_wdata[15:0]}};
        end
        default: begin
          req_wstrb = 4'b1111;
          req_wrep  = req_wdata;
        end
      endcase
    end
    req_ok = req_legal && req_aligned;
  end

  // Lane selection and extension of the returned memory word
  always_comb begin
    ld_byte = mem_rdata[8*off_q +: 8];
    ld_half = mem_rdata[16*off_q[1] +: 16];
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; mem_ready wins over a coincident timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (req_valid) state_d = req_ok ? S_ACCESS : S_FAULT;
      S_ACCESS: begin
        if (mem_ready)              state_d = S_DONE;
        else if (cnt_q == CNT_LAST) state_d = S_FAULT;
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; mem_* payload comes from the capture registers
  always_comb begin
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE) || (state_q == S_FAULT);
    fault     = (state_q == S_FAULT);
    mem_valid = (state_q == S_ACCESS);
    mem_we    = (state_q == S_ACCESS) && we_q;
    mem_addr  = addr_q;
    mem_wstrb = wstrb_q;
    mem_wdata = wdata_q;
    rdata     = rdata_q;
  end

  // Request capture, wait counter and load-data register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= 8'h0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      addr_q  <= 32'h0;
      wstrb_q <= 4'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            we_q  <= req_we;
            f3_q  <= req_funct3;
            off_q <= req_addr[1:0];
            cnt_q <= 8'h0;
            if (req_ok) begin
              addr_q  <= {req_addr[31:2], 2'b00};
              wstrb_q <= req_wstrb;
              wdata_q <= req_wrep;
            end
          end
        end
        S_ACCESS: begin
          if (mem_ready) begin
            if (!we_q) rdata_q <= ld_ext;
          end else begin
            cnt_q <= cnt_q + 8'h1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: two instances (default timeout and timeout 4)
// share one stimulus stream. A transaction-level model predicts, for each
// cycle of each request, the full output picture of both instances.
module tb_mem_access_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, req_valid, req_we, mem_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, mem_rdata;

  logic [1:0]       busy, done, fault, mem_valid, mem_we;
  logic [1:0][31:0] rdata, mem_addr, mem_wdata;
  logic [1:0][3:0]  mem_wstrb;

  mem_access_unit #(.TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy[0]), .done(done[0]), .fault(fault[0]), .rdata(rdata[0]),
    .mem_valid(mem_valid[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
    .mem_wstrb(mem_wstrb[0]), .mem_wdata(mem_wdata[0]),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata));

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut_t4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .busy(busy[1]), .done(done[1]), .fault(fault[1]), .rdata(rdata[1]),
    .mem_valid(mem_valid[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
    .mem_wstrb(mem_wstrb[1]), .mem_wdata(mem_wdata[1]),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata));

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic [1:0]       e_busy, e_done, e_fault, e_valid, e_we;
  logic [1:0][31:0] e_addr, e_wdata, m_rdata;
  logic [1:0][3:0]  e_wstrb;

  task automatic chk(input string name, input int d, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d t=%0t actual=%h expected=%h", name, d, $time, act, exp);
    end
  endtask

  // Model helpers
  function automatic bit m_ok(input bit we, input [2:0] f3, input [31:0] a);
    bit legal;
    if (we) legal = (f3 == 0) || (f3 == 1) || (f3 == 2);
    else    legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
    if ((f3 == 1 || f3 == 5) && (a % 2 != 0)) return 1'b0;
    if (f3 == 2 && (a % 4 != 0)) return 1'b0;
    return legal;
  endfunction

  function automatic [3:0] m_strb(input bit we, input [2:0] f3, input [31:0] a);
    int off;
    off = a % 4;
    if (!we) return 4'h0;
    if (f3 == 0) return 4'(1 << off);
    if (f3 == 1) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic [31:0] m_wrep(input [2:0] f3, input [31:0] w);
    if (f3 == 0) return (w & 32'hFF) * 32'h01010101;
    if (f3 == 1) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  function automatic [31:0] m_ext(input [2:0] f3, input [31:0] a, input [31:0] rd);
    logic [31:0] b, h;
    int off;
    off = a % 4;
    b = (rd >> (8 * off)) & 32'hFF;
    h = (rd >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0: return (b >= 128) ? (b | 32'hFFFFFF00) : b;
      3'd1: return (h >= 32768) ? (h | 32'hFFFF0000) : h;
      3'd4: return b;
      3'd5: return h;
      default: return rd;
    endcase
  endfunction

  // Per-cycle comparison of both instances against the model picture
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        chk("busy",      d, 32'(busy[d]),      32'(e_busy[d]));
        chk("done",      d, 32'(done[d]),      32'(e_done[d]));
        chk("fault",     d, 32'(fault[d]),     32'(e_fault[d]));
        chk("mem_valid", d, 32'(mem_valid[d]), 32'(e_valid[d]));
        chk("mem_we",    d, 32'(mem_we[d]),    32'(e_we[d]));
        chk("rdata",     d, rdata[d],          m_rdata[d]);
        if (e_valid[d]) begin
          chk("mem_addr",  d, mem_addr[d],         e_addr[d]);
          chk("mem_wstrb", d, 32'(mem_wstrb[d]),   32'(e_wstrb[d]));
          if (e_we[d]) chk("mem_wdata", d, mem_wdata[d], e_wdata[d]);
        end
      end
    end
  end

  // One request; dly = ACCESS cycles before mem_ready (ready in cycle 1+dly)
  task automatic txn(input bit we, input [2:0] f3, input [31:0] a,
                     input [31:0] w, input int dly, input [31:0] rd,
                     input bit hold);
    int tmo[2];
    int nacc[2];
    bit flt[2];
    bit ok;
    int last;
    bit acc, fin;
    tmo[0] = 255;
    tmo[1] = 4;
    ok = m_ok(we, f3, a);
    last = 0;
    for (int d = 0; d < 2; d++) begin
      if (!ok)              begin nacc[d] = 0;       flt[d] = 1'b1; end
      else if (dly < tmo[d]) begin nacc[d] = dly + 1; flt[d] = 1'b0; end
      else                  begin nacc[d] = tmo[d];  flt[d] = 1'b1; end
      if (nacc[d] + 1 > last) last = nacc[d] + 1;
    end
    for (int c = 0; c <= last + 1; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        req_we = we; req_funct3 = f3; req_addr = a; req_wdata = w;
      end
      req_valid = (c == 0) || (hold && c <= last);
      mem_ready = ok && (c == 1 + dly);
      mem_rdata = rd;
      for (int d = 0; d < 2; d++) begin
        acc = (c >= 1) && (c <= nacc[d]);
        fin = (c == nacc[d] + 1);
        e_busy[d]  = acc || fin;
        e_valid[d] = acc;
        e_we[d]    = acc && we;
        e_done[d]  = fin;
        e_fault[d] = fin && flt[d];
        e_addr[d]  = a & 32'hFFFFFFFC;
        e_wstrb[d] = m_strb(we, f3, a);
        e_wdata[d] = m_wrep(f3, w);
        if (fin && !flt[d] && !we) m_rdata[d] = m_ext(f3, a, rd);
      end
    end
    req_valid = 1'b0;
    mem_ready = 1'b0;
  endtask

  task automatic set_idle();
    e_busy = '0; e_done = '0; e_fault = '0; e_valid = '0; e_we = '0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    set_idle();
    e_addr = '0; e_wdata = '0; e_wstrb = '0; m_rdata = '0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_done",  d, 32'(done[d]),      32'h0);
      chk("rst_fault", d, 32'(fault[d]),     32'h0);
      chk("rst_rdata", d, rdata[d],          32'h0);
      chk("rst_valid", d, 32'(mem_valid[d]), 32'h0);
      chk("rst_we",    d, 32'(mem_we[d]),    32'h0);
      chk("rst_addr",  d, mem_addr[d],       32'h0);
      chk("rst_wstrb", d, 32'(mem_wstrb[d]), 32'h0);
      chk("rst_wdata", d, mem_wdata[d],      32'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;

    // sw 0x100, zero wait states
    fork
      txn(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 0, 32'h0, 1'b0);
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("sw_wstrb_lit", 0, 32'(mem_wstrb[0]), 32'hF);
        chk("sw_addr_lit",  0, mem_addr[0],       32'h100);
        @(negedge clk);
        chk("sw_done_c2_lit", 0, 32'(done[0]), 32'h1);
      end
    join
    txn(1'b0, 3'd2, 32'h100, 32'h0, 0, 32'hDEADBEEF, 1'b0);
    chk("lw_lit", 0, rdata[0], 32'hDEADBEEF);
    txn(1'b0, 3'd0, 32'h3, 32'h0, 0, 32'h80F17F22, 1'b0);
    chk("lb_lit", 0, rdata[0], 32'hFFFFFF80);
    txn(1'b0, 3'd4, 32'h3, 32'h0, 1, 32'h80F17F22, 1'b0);
    chk("lbu_lit", 0, rdata[0], 32'h00000080);
    txn(1'b0, 3'd1, 32'h2, 32'h0, 2, 32'h80F17F22, 1'b0);
    chk("lh_lit", 0, rdata[0], 32'hFFFF80F1);
    txn(1'b0, 3'd5, 32'h0, 32'h0, 0, 32'h80F17F22, 1'b0);
    chk("lhu_lit", 0, rdata[0], 32'h00007F22);

    // sb 0x102
    fork
      txn(1'b1, 3'd0, 32'h102, 32'h000000AB, 1, 32'h0, 1'b0);
      begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("sb_wstrb_lit", 0, 32'(mem_wstrb[0]), 32'h4);
        chk("sb_wdata_lit", 0, mem_wdata[0],      32'hABABABAB);
        chk("sb_addr_lit",  0, mem_addr[0],       32'h100);
      end
    join

    // Five wait states: the timeout-4 instance must fault after 4 ACCESS cycles
    fork
      txn(1'b0, 3'd2, 32'h40, 32'h0, 5, 32'h12345678, 1'b0);
      begin
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("t4_done_lit",  1, 32'(done[1]),      32'h1);
        chk("t4_fault_lit", 1, 32'(fault[1]),     32'h1);
        chk("t4_valid_lit", 1, 32'(mem_valid[1]), 32'h0);
        chk("wait_valid_lit", 0, 32'(mem_valid[0]), 32'h1);
      end
    join
    chk("wait_rdata_lit", 0, rdata[0], 32'h12345678);

    // Misaligned and illegal loads
    txn(1'b0, 3'd2, 32'h101, 32'h0, 0, 32'hCAFEF00D, 1'b0);
    chk("misalign_rdata_lit", 0, rdata[0], 32'h12345678);
    txn(1'b0, 3'd3, 32'h100, 32'h0, 0, 32'hCAFEF00D, 1'b0);

    // req_valid held through the access is not re-accepted
    txn(1'b0, 3'd2, 32'h80, 32'h0, 2, 32'h0BADF00D, 1'b1);

    // Reset in the middle of ACCESS
    chk_en = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h200;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #3;
    chk("pre_rst_valid", 0, 32'(mem_valid[0]), 32'h1);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_mid_valid", d, 32'(mem_valid[d]), 32'h0);
      chk("rst_mid_rdata", d, rdata[d],          32'h0);
    end
    m_rdata = '0;
    set_idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    mem_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    mem_ready = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      bit          we;
      logic [2:0]  f3;
      logic [31:0] a;
      int          dly;
      we  = 1'($urandom_range(0, 1));
      f3  = 3'($urandom_range(0, 7));
      a   = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      dly = $urandom_range(0, 6);
      txn(we, f3, a, $urandom, dly, $urandom,
          (dly < 3) && ($urandom_range(0, 3) == 0));
    end

    @(posedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
